// File: rtl/lfsr_prng.sv
// WIDTH-bit LFSR PRNG with runtime Fibonacci/Galois selection, seed loading and
// zero-state recovery; the serial stream is packed MSB-first into OUT_W-bit words.
module lfsr_prng #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic             bit_out,
  output logic [OUT_W-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             lockup
);

  localparam int            CW   = (OUT_W > 2) ? $clog2(OUT_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(OUT_W - 1);

  logic [WIDTH-1:0] s, s_next;
  logic [OUT_W-1:0] sr, sr_next;
  logic [CW-1:0]    cnt;
  logic             fb, obit, wrap, xfer, stall, step;

  assign fb      = ^(s & TAPS);
  assign obit    = mode ? s[0] : s[WIDTH-1];
  assign bit_out = obit;
  assign s_next  = mode ? ((s >> 1) ^ (s[0] ? TAPS : '0)) : {s[WIDTH-2:0], fb};
  assign sr_next = {sr[OUT_W-2:0], obit};

  // Hold the generator only when the finishing step of a word has nowhere to go.
  assign wrap  = (cnt == LAST);
  assign xfer  = word_valid & word_ready;
  assign stall = word_valid & ~word_ready & wrap;
  assign step  = en & ~seed_load & ~stall;

  // rst_n is active-high here despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s          <= SEED;
      cnt        <= '0;
      sr         <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      lockup     <= 1'b0;
    end else begin
      lockup <= 1'b0;
      if (seed_load) begin
        s          <= (seed_in == '0) ? SEED : seed_in;
        lockup     <= (seed_in == '0);
        cnt        <= '0;
        sr         <= '0;
        word_valid <= 1'b0;
      end else begin
        if (step) begin
          if (s_next == '0) begin
            s      <= SEED;
            lockup <= 1'b1;
          end else begin
            s <= s_next;
          end
          sr  <= sr_next;
          cnt <= wrap ? '0 : cnt + CW'(1);
          if (wrap) word_out <= sr_next;
        end
        if (step && wrap)
          word_valid <= 1'b1;
        else if (xfer)
          word_valid <= 1'b0;
      end
    end
  end

endmodule
